// File: rtl/eq_sdp_pkg.sv
// Shared defaults and operation encodings for the eq_sdp inverse pipeline.
// The forward pipe computes n = op2(op1(a, b), c); this block recovers a.
package eq_sdp_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // First forward op (ctl_1): 0 means m = a + b, 1 means m = a - b.
  localparam logic OP1_ADD = 1'b0;
  localparam logic OP1_SUB = 1'b1;

  // Second forward op (ctl_2): 1 means n = m + c, 0 means n = m - c.
  localparam logic OP2_SUB = 1'b0;
  localparam logic OP2_ADD = 1'b1;

endpackage

// File: rtl/eq_sdp_stage.sv
// Generic pipeline register with a valid bit; loads only when the pipe advances,
// otherwise holds both valid and payload.
module eq_sdp_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // NOTE: non-blocking assignments let every stage sample its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/eq_sdp_inv.sv
// Three-stage inverse of the forward add/sub pipe: S1 captures, S2 undoes op2,
// S3 undoes op1 and drives a_out. One global advance keeps beats in order under stall.
module eq_sdp_inv
  import eq_sdp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ctl_1,
  input  logic             ctl_2,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int S1_W = 3 * WIDTH + 2;
  localparam int S2_W = 2 * WIDTH + 1;

  logic             adv;
  logic             s1_v;
  logic             s2_v;
  logic [S1_W-1:0]  s1_d;
  logic [S1_W-1:0]  s1_q;
  logic [S2_W-1:0]  s2_d;
  logic [S2_W-1:0]  s2_q;

  logic [WIDTH-1:0] s1_n;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  logic             s1_ctl_1;
  logic             s1_ctl_2;
  logic [WIDTH-1:0] s2_m;
  logic [WIDTH-1:0] s2_b;
  logic             s2_ctl_1;
  logic [WIDTH-1:0] m_nxt;
  logic [WIDTH-1:0] a_nxt;

  // The whole pipe moves together whenever the output slot is free or being drained,
  // so a beat entering S1 while S3 empties needs no special case.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign s1_d = {ctl_2, ctl_1, c, b, n};

  eq_sdp_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (in_valid),
    .in_data   (s1_d),
    .out_valid (s1_v),
    .out_data  (s1_q)
  );

  assign {s1_ctl_2, s1_ctl_1, s1_c, s1_b, s1_n} = s1_q;

  // NOTE: each always_comb assigns its output on every path, so no latch can be inferred.
  always_comb begin
    m_nxt = (s1_ctl_2 == OP2_ADD) ? s1_n - s1_c : s1_n + s1_c;
  end

  assign s2_d = {s1_ctl_1, s1_b, m_nxt};

  eq_sdp_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (s1_v),
    .in_data   (s2_d),
    .out_valid (s2_v),
    .out_data  (s2_q)
  );

  assign {s2_ctl_1, s2_b, s2_m} = s2_q;

  always_comb begin
    a_nxt = (s2_ctl_1 == OP1_ADD) ? s2_m - s2_b : s2_m + s2_b;
  end

  eq_sdp_stage #(.W(WIDTH)) u_s3 (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .in_valid  (s2_v),
    .in_data   (a_nxt),
    .out_valid (out_valid),
    .out_data  (a_out)
  );

  // Counts output handshakes; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule
